// File: rtl/register_file_pkg.sv
// Shared sizing constants and types for the two-read/one-write register file.
package register_file_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 4;
    localparam int NUM_REGS       = 2 ** DEFAULT_ADDR_W;
    localparam int ZERO_REG       = 0;

    typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEFAULT_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/register_file.sv
// Two combinational read ports, one synchronous write port, register 0 hard-wired to zero.
// Optional write-through on the read ports when REGFILE_BYPASS_EN is defined.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] RInA,
    input  logic [ADDR_W-1:0] RInB,
    output logic [DATA_W-1:0] OutA,
    output logic [DATA_W-1:0] OutB,
    input  logic              WEn,
    input  logic [ADDR_W-1:0] RDest,
    input  logic [DATA_W-1:0] WData
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs [NREGS];
    logic              wr_valid;

    assign wr_valid = WEn && (RDest != ZERO_ADDR);

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_valid) begin
            regs[RDest] <= WData;
        end
    end

    // Register 0 is forced to zero on read so it is valid even before the first reset.
    always_comb begin
        OutA = '0;
        if (RInA != ZERO_ADDR) begin
            OutA = regs[RInA];
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_valid && !RST && (RInA == RDest)) begin
            OutA = WData;
        end
`endif
    end

    always_comb begin
        OutB = '0;
        if (RInB != ZERO_ADDR) begin
            OutB = regs[RInB];
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_valid && !RST && (RInB == RDest)) begin
            OutB = WData;
        end
`endif
    end

endmodule

// File: tb/tb_register_file.sv
// Directed, table-driven bench for register_file; expectations follow REGFILE_BYPASS_EN.
module tb_register_file;
    import register_file_pkg::*;

    logic      CLK;
    logic      RST;
    reg_addr_t RInA;
    reg_addr_t RInB;
    reg_data_t OutA;
    reg_data_t OutB;
    logic      WEn;
    reg_addr_t RDest;
    reg_data_t WData;

    int n_checks = 0;
    int n_errors = 0;

    register_file dut (
        .CLK   (CLK),
        .RST   (RST),
        .RInA  (RInA),
        .RInB  (RInB),
        .OutA  (OutA),
        .OutB  (OutB),
        .WEn   (WEn),
        .RDest (RDest),
        .WData (WData)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic      rst;
        logic      wen;
        reg_addr_t rdest;
        reg_data_t wdata;
        reg_addr_t rina;
        reg_addr_t rinb;
        reg_data_t exp_a;
        reg_data_t exp_b;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vec [NVEC];

    task automatic check(input string name, input reg_data_t act, input reg_data_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive on the falling edge and sample 2 time units later, well before the next rising edge.
    task automatic drive(input logic rst, input logic wen, input reg_addr_t rdest,
                         input reg_data_t wdata, input reg_addr_t rina, input reg_addr_t rinb);
        @(negedge CLK);
        RST   = rst;
        WEn   = wen;
        RDest = rdest;
        WData = wdata;
        RInA  = rina;
        RInB  = rinb;
        #2;
    endtask

    reg_data_t exp_byp;
    reg_data_t pattern;

    initial begin
        RST = 1'b0; WEn = 1'b0; RDest = '0; WData = '0; RInA = '0; RInB = '0;

        //          rst   wen   rdest  wdata          rina   rinb   exp_a          exp_b
        vec[0]  = '{1'b1, 1'b0, 4'd0,  32'h0,         4'd0,  4'd0,  32'h0,         32'h0};
        vec[1]  = '{1'b0, 1'b1, 4'd2,  32'h7,         4'd0,  4'd1,  32'h0,         32'h0};
        vec[2]  = '{1'b0, 1'b0, 4'd0,  32'h0,         4'd0,  4'd2,  32'h0,         32'h7};
        vec[3]  = '{1'b0, 1'b1, 4'd0,  32'hDEADBEEF,  4'd0,  4'd2,  32'h0,         32'h7};
        vec[4]  = '{1'b0, 1'b0, 4'd0,  32'h0,         4'd0,  4'd0,  32'h0,         32'h0};
        vec[5]  = '{1'b0, 1'b1, 4'd5,  32'h11111111,  4'd2,  4'd0,  32'h7,         32'h0};
        vec[6]  = '{1'b0, 1'b1, 4'd15, 32'h22222222,  4'd5,  4'd2,  32'h11111111,  32'h7};
        vec[7]  = '{1'b0, 1'b0, 4'd0,  32'h0,         4'd5,  4'd15, 32'h11111111,  32'h22222222};
        vec[8]  = '{1'b0, 1'b0, 4'd3,  32'hFFFFFFFF,  4'd15, 4'd15, 32'h22222222,  32'h22222222};
        vec[9]  = '{1'b0, 1'b1, 4'd14, 32'h000000E0,  4'd3,  4'd15, 32'h0,         32'h22222222};
        vec[10] = '{1'b0, 1'b1, 4'd1,  32'h13579BDF,  4'd14, 4'd6,  32'h000000E0,  32'h0};
        vec[11] = '{1'b1, 1'b1, 4'd4,  32'h9,         4'd1,  4'd15, 32'h13579BDF,  32'h22222222};
        vec[12] = '{1'b0, 1'b0, 4'd0,  32'h0,         4'd4,  4'd15, 32'h0,         32'h0};
        vec[13] = '{1'b0, 1'b0, 4'd0,  32'h0,         4'd1,  4'd5,  32'h0,         32'h0};
        vec[14] = '{1'b0, 1'b1, 4'd6,  32'h5A5A5A5A,  4'd14, 4'd2,  32'h0,         32'h0};

        for (int i = 0; i < NVEC; i++) begin
            drive(vec[i].rst, vec[i].wen, vec[i].rdest, vec[i].wdata, vec[i].rina, vec[i].rinb);
            check($sformatf("vec%0d_outa", i), OutA, vec[i].exp_a);
            check($sformatf("vec%0d_outb", i), OutB, vec[i].exp_b);
        end

        // Same-cycle read of the register being written: r6 currently holds 0x5A5A5A5A.
`ifdef REGFILE_BYPASS_EN
        exp_byp = 32'hA5A5A5A5;
`else
        exp_byp = 32'h5A5A5A5A;
`endif
        drive(1'b0, 1'b1, 4'd6, 32'hA5A5A5A5, 4'd6, 4'd6);
        check("same_cycle_r6_a", OutA, exp_byp);
        check("same_cycle_r6_b", OutB, exp_byp);

        // Write to r0 must never appear on a read port, bypassed or not.
        drive(1'b0, 1'b1, 4'd0, 32'hCAFEF00D, 4'd0, 4'd6);
        check("r0_no_bypass", OutA, 32'h0);
        check("r6_after_write", OutB, 32'hA5A5A5A5);

        // No write-through while reset is asserted; the write itself is lost.
        drive(1'b1, 1'b1, 4'd7, 32'h77777777, 4'd7, 4'd6);
        check("rst_no_bypass_r7", OutA, 32'h0);
        check("rst_pre_edge_r6", OutB, 32'hA5A5A5A5);

        drive(1'b0, 1'b0, 4'd0, 32'h0, 4'd0, 4'd0);
        for (int a = 0; a < NUM_REGS; a++) begin
            RInA = reg_addr_t'(a);
            RInB = reg_addr_t'(NUM_REGS - 1 - a);
            #1;
            check($sformatf("post_rst_a_r%0d", a), OutA, 32'h0);
            check($sformatf("post_rst_b_r%0d", NUM_REGS - 1 - a), OutB, 32'h0);
        end

        // Unique value per register exposes any address aliasing.
        for (int a = 1; a < NUM_REGS; a++) begin
            pattern = 32'h01010101 * a + 32'h00C0FFEE;
            drive(1'b0, 1'b1, reg_addr_t'(a), pattern, 4'd0, 4'd0);
        end
        drive(1'b0, 1'b0, 4'd0, 32'h0, 4'd0, 4'd0);
        for (int a = 0; a < NUM_REGS; a++) begin
            pattern = (a == 0) ? 32'h0 : 32'h01010101 * a + 32'h00C0FFEE;
            RInA = reg_addr_t'(a);
            RInB = reg_addr_t'(a);
            #1;
            check($sformatf("decode_a_r%0d", a), OutA, pattern);
            check($sformatf("decode_b_r%0d", a), OutB, pattern);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
